// File: rtl/video_test_timing_ctrl_pkg.sv
// Shared types and defaults for the video test-pattern timing controller.
package video_test_timing_ctrl_pkg;

   localparam int unsigned W              = 11;
   localparam int unsigned PIPE_DELAY_DEF = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } run_state_e;

   // One raster timing set; used for both the shadow and the active copy.
   typedef struct packed {
      logic [W-1:0] h_total;
      logic [W-1:0] h_sync;
      logic [W-1:0] h_dstart;
      logic [W-1:0] h_dend;
      logic [W-1:0] v_total;
      logic [W-1:0] v_sync;
      logic [W-1:0] v_dstart;
      logic [W-1:0] v_dend;
   } timing_cfg_t;

   typedef struct packed {
      logic hsync;
      logic vsync;
      logic de;
      logic frame_start;
   } sync_flags_t;

   // Inclusive window end from an exclusive bound; 0 wraps to all-ones.
   function automatic logic [W-1:0] last_index(input logic [W-1:0] dend);
      return dend - W'(1);
   endfunction

endpackage

// File: rtl/video_test_timing_ctrl_if.sv
// Timing configuration valid/ready channel.
interface video_test_timing_ctrl_if;
   import video_test_timing_ctrl_pkg::*;

   logic         cfg_valid;
   logic         cfg_ready;
   logic [W-1:0] cfg_h_total;
   logic [W-1:0] cfg_h_sync;
   logic [W-1:0] cfg_h_dstart;
   logic [W-1:0] cfg_h_dend;
   logic [W-1:0] cfg_v_total;
   logic [W-1:0] cfg_v_sync;
   logic [W-1:0] cfg_v_dstart;
   logic [W-1:0] cfg_v_dend;

   modport master (
      output cfg_valid, cfg_h_total, cfg_h_sync, cfg_h_dstart, cfg_h_dend,
             cfg_v_total, cfg_v_sync, cfg_v_dstart, cfg_v_dend,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid, cfg_h_total, cfg_h_sync, cfg_h_dstart, cfg_h_dend,
             cfg_v_total, cfg_v_sync, cfg_v_dstart, cfg_v_dend,
      output cfg_ready
   );

endinterface

// File: rtl/video_delay_line.sv
// Fixed-depth shift register used to align sync/de flags with the pattern datapath.
module video_delay_line #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned DEPTH = 1
) (
   input  logic             pclk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   localparam int unsigned BITS = DEPTH * WIDTH;

   logic [BITS-1:0] stage_q;
   logic [BITS-1:0] stage_d;

   // Newest sample enters at the bottom, oldest leaves from the top.
   if (DEPTH > 1) begin : g_shift
      always_comb stage_d = {stage_q[BITS-WIDTH-1:0], d};
   end else begin : g_single
      always_comb stage_d = d;
   end

   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) stage_q <= '0;
      else          stage_q <= stage_d;
   end

   assign q = stage_q[BITS-1 -: WIDTH];

endmodule

// File: rtl/video_test_timing_ctrl.sv
// Raster counters, window bounds and delayed sync/de generation for the test-pattern path;
// new timing is taken through a valid/ready channel and applied only at a frame boundary.
module video_test_timing_ctrl
   import video_test_timing_ctrl_pkg::*;
#(
   parameter int unsigned PIPE_DELAY = PIPE_DELAY_DEF
) (
   input  logic                           pclk,
   input  logic                           reset_n,
   input  logic                           enable,
   video_test_timing_ctrl_if.slave        cfg,
   output logic [W-1:0]                   px,
   output logic [W-1:0]                   py,
   output logic [W-1:0]                   xstart,
   output logic [W-1:0]                   xend,
   output logic [W-1:0]                   ystart,
   output logic [W-1:0]                   yend,
   output logic                           hsync,
   output logic                           vsync,
   output logic                           de,
   output logic                           frame_start
);

   run_state_e   state_q, state_d;
   logic [W-1:0] hcnt_q, hcnt_d;
   logic [W-1:0] vcnt_q, vcnt_d;
   logic         pending_q, pending_d;
   timing_cfg_t  shadow_q, shadow_d;
   timing_cfg_t  active_q, active_d;
   logic [W-1:0] xstart_q, xstart_d, xend_q, xend_d;
   logic [W-1:0] ystart_q, ystart_d, yend_q, yend_d;
   logic         eof;
   sync_flags_t  flags_raw;
   sync_flags_t  flags_dly;

   // State register
   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Next state follows the enable request
   always_comb begin
      state_d = ST_IDLE;
      if (enable) state_d = ST_RUN;
   end

   // Raw flags from the current raster position
   always_comb begin
      flags_raw = '0;
      if (state_q == ST_RUN) begin
         flags_raw.hsync       = hcnt_q < active_q.h_sync;
         flags_raw.vsync       = vcnt_q < active_q.v_sync;
         flags_raw.de          = (hcnt_q >= active_q.h_dstart) && (hcnt_q < active_q.h_dend) &&
                                 (vcnt_q >= active_q.v_dstart) && (vcnt_q < active_q.v_dend);
         flags_raw.frame_start = (hcnt_q == '0) && (vcnt_q == '0);
      end
   end

   // Raster counters; leaving RUN parks them at the origin on the same edge
   always_comb begin
      hcnt_d = hcnt_q;
      vcnt_d = vcnt_q;
      eof    = 1'b0;
      if (state_q == ST_RUN) begin
         if (hcnt_q == active_q.h_total) begin
            hcnt_d = '0;
            if (vcnt_q == active_q.v_total) begin
               vcnt_d = '0;
               eof    = 1'b1;
            end else begin
               vcnt_d = vcnt_q + W'(1);
            end
         end else begin
            hcnt_d = hcnt_q + W'(1);
         end
      end
      if (state_d == ST_IDLE) begin
         hcnt_d = '0;
         vcnt_d = '0;
      end
   end

   // Config capture into shadow, then whole-set copy to active at EOF or while idle
   always_comb begin
      pending_d = pending_q;
      shadow_d  = shadow_q;
      active_d  = active_q;
      if (cfg.cfg_valid && !pending_q) begin
         shadow_d = '{h_total:  cfg.cfg_h_total,  h_sync:   cfg.cfg_h_sync,
                      h_dstart: cfg.cfg_h_dstart, h_dend:   cfg.cfg_h_dend,
                      v_total:  cfg.cfg_v_total,  v_sync:   cfg.cfg_v_sync,
                      v_dstart: cfg.cfg_v_dstart, v_dend:   cfg.cfg_v_dend};
         pending_d = 1'b1;
      end else if (pending_q && (eof || (state_q == ST_IDLE))) begin
         active_d  = shadow_q;
         pending_d = 1'b0;
      end
      xstart_d = active_d.h_dstart;
      xend_d   = last_index(active_d.h_dend);
      ystart_d = active_d.v_dstart;
      yend_d   = last_index(active_d.v_dend);
   end

   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         hcnt_q    <= '0;
         vcnt_q    <= '0;
         pending_q <= 1'b0;
         shadow_q  <= '0;
         active_q  <= '0;
         xstart_q  <= '0;
         xend_q    <= '1;
         ystart_q  <= '0;
         yend_q    <= '1;
      end else begin
         hcnt_q    <= hcnt_d;
         vcnt_q    <= vcnt_d;
         pending_q <= pending_d;
         shadow_q  <= shadow_d;
         active_q  <= active_d;
         xstart_q  <= xstart_d;
         xend_q    <= xend_d;
         ystart_q  <= ystart_d;
         yend_q    <= yend_d;
      end
   end

   video_delay_line #(
      .WIDTH ($bits(sync_flags_t)),
      .DEPTH (PIPE_DELAY)
   ) u_flag_dly (
      .pclk    (pclk),
      .reset_n (reset_n),
      .d       (flags_raw),
      .q       (flags_dly)
   );

   assign cfg.cfg_ready = ~pending_q;
   assign px            = hcnt_q;
   assign py            = vcnt_q;
   assign xstart        = xstart_q;
   assign xend          = xend_q;
   assign ystart        = ystart_q;
   assign yend          = yend_q;
   assign hsync         = flags_dly.hsync;
   assign vsync         = flags_dly.vsync;
   assign de            = flags_dly.de;
   assign frame_start   = flags_dly.frame_start;

endmodule

// File: tb/tb_video_test_timing_ctrl.sv
// Self-checking bench: per-cycle comparison against a frame-position model, a table of
// timing sets with per-frame flag counts, and directed handshake/enable/reset sequences.
module tb_video_test_timing_ctrl;
   import video_test_timing_ctrl_pkg::*;

   localparam int unsigned PD = PIPE_DELAY_DEF;

   logic         pclk = 1'b0;
   logic         reset_n = 1'b0;
   logic         enable = 1'b0;
   logic [W-1:0] px, py, xstart, xend, ystart, yend;
   logic         hsync, vsync, de, frame_start;

   video_test_timing_ctrl_if vif();

   video_test_timing_ctrl #(.PIPE_DELAY(PD)) dut (
      .pclk(pclk), .reset_n(reset_n), .enable(enable), .cfg(vif),
      .px(px), .py(py), .xstart(xstart), .xend(xend), .ystart(ystart), .yend(yend),
      .hsync(hsync), .vsync(vsync), .de(de), .frame_start(frame_start)
   );

   always #5 pclk = ~pclk;

   int checks = 0;
   int errors = 0;

   // Model: linear position inside the frame plus a history of raw flag values
   timing_cfg_t m_act, m_shd;
   bit          m_pend, m_run;
   int unsigned m_pos;
   logic [3:0]  m_hist[$];

   typedef struct {
      timing_cfg_t c;
      logic [W-1:0] xend;
      logic [W-1:0] yend;
      int unsigned  len;
      int unsigned  n_de;
      int unsigned  n_hs;
      int unsigned  n_fs;
   } vec_t;

   vec_t vecs[4];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
      end
   endtask

   task automatic fail_timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s timeout t=%0t", name, $time);
   endtask

   function automatic timing_cfg_t mk(input int unsigned ht, hs, hds, hde, vt, vs, vds, vde);
      timing_cfg_t c;
      c.h_total = W'(ht);  c.h_sync = W'(hs);  c.h_dstart = W'(hds); c.h_dend = W'(hde);
      c.v_total = W'(vt);  c.v_sync = W'(vs);  c.v_dstart = W'(vds); c.v_dend = W'(vde);
      return c;
   endfunction

   function automatic timing_cfg_t rand_cfg();
      return mk($urandom_range(0, 12), $urandom_range(0, 14), $urandom_range(0, 14),
                $urandom_range(0, 15), $urandom_range(0, 6), $urandom_range(0, 8),
                $urandom_range(0, 8), $urandom_range(0, 9));
   endfunction

   task automatic model_reset();
      m_act = '0; m_shd = '0; m_pend = 1'b0; m_run = 1'b0; m_pos = 0;
      m_hist = {};
      for (int i = 0; i < int'(PD); i++) m_hist.push_back(4'b0);
   endtask

   function automatic logic [3:0] model_raw();
      int unsigned hl, x, y;
      logic hs, vs, dd, fs;
      hl = 32'(m_act.h_total) + 1;
      x  = m_pos % hl;
      y  = m_pos / hl;
      if (!m_run) return 4'b0;
      hs = x < 32'(m_act.h_sync);
      vs = y < 32'(m_act.v_sync);
      dd = (x >= 32'(m_act.h_dstart)) && (x < 32'(m_act.h_dend)) &&
           (y >= 32'(m_act.v_dstart)) && (y < 32'(m_act.v_dend));
      fs = (m_pos == 0);
      return {hs, vs, dd, fs};
   endfunction

   task automatic model_step(input bit en, input bit valid, input timing_cfg_t ci);
      int unsigned flen;
      bit eof, acc, sw;
      flen = (32'(m_act.h_total) + 1) * (32'(m_act.v_total) + 1);
      eof  = m_run && (m_pos == flen - 1);
      m_hist.push_back(model_raw());
      void'(m_hist.pop_front());
      acc = valid && !m_pend;
      sw  = m_pend && (eof || !m_run);
      if (!en)        m_pos = 0;
      else if (m_run) m_pos = (m_pos + 1) % flen;
      else            m_pos = 0;
      if (acc) begin
         m_shd  = ci;
         m_pend = 1'b1;
      end else if (sw) begin
         m_act  = m_shd;
         m_pend = 1'b0;
      end
      m_run = en;
   endtask

   task automatic check_all();
      int unsigned hl;
      logic [W-1:0] xe, ye;
      hl = 32'(m_act.h_total) + 1;
      xe = m_act.h_dend - 11'd1;
      ye = m_act.v_dend - 11'd1;
      chk("px", 32'(px), m_pos % hl);
      chk("py", 32'(py), m_pos / hl);
      chk("xstart", 32'(xstart), 32'(m_act.h_dstart));
      chk("xend", 32'(xend), 32'(xe));
      chk("ystart", 32'(ystart), 32'(m_act.v_dstart));
      chk("yend", 32'(yend), 32'(ye));
      chk("cfg_ready", 32'(vif.cfg_ready), 32'(!m_pend));
      chk("flags_hs_vs_de_fs", 32'({hsync, vsync, de, frame_start}), 32'(m_hist[0]));
   endtask

   task automatic cycle();
      timing_cfg_t ci;
      ci = mk(vif.cfg_h_total, vif.cfg_h_sync, vif.cfg_h_dstart, vif.cfg_h_dend,
              vif.cfg_v_total, vif.cfg_v_sync, vif.cfg_v_dstart, vif.cfg_v_dend);
      model_step(enable, vif.cfg_valid, ci);
      @(posedge pclk);
      @(negedge pclk);
      check_all();
   endtask

   task automatic set_cfg(input timing_cfg_t c);
      vif.cfg_h_total = c.h_total;   vif.cfg_h_sync = c.h_sync;
      vif.cfg_h_dstart = c.h_dstart; vif.cfg_h_dend = c.h_dend;
      vif.cfg_v_total = c.v_total;   vif.cfg_v_sync = c.v_sync;
      vif.cfg_v_dstart = c.v_dstart; vif.cfg_v_dend = c.v_dend;
   endtask

   task automatic wait_xy(input int unsigned x, input int unsigned y, input string name);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         if (32'(px) == x && 32'(py) == y) found = 1'b1;
         else cycle();
      end
      if (!found) fail_timeout(name);
   endtask

   task automatic wait_ready(input string name);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         if (vif.cfg_ready) found = 1'b1;
         else cycle();
      end
      if (!found) fail_timeout(name);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      timing_cfg_t c19, cb;
      int unsigned n_de, n_hs, n_fs;
      bit found;

      // len, de / hsync / frame_start counts over one frame, derived by hand
      vecs[0] = '{mk(5, 1, 0, 0, 2, 0, 0, 2),  11'h7FF, 11'd1,   18,  0,  3, 1};
      vecs[1] = '{mk(0, 0, 0, 0, 0, 0, 0, 0),  11'h7FF, 11'h7FF,  1,  0,  0, 1};
      vecs[2] = '{mk(7, 8, 2, 10, 3, 0, 0, 4), 11'd9,   11'd3,   32, 24, 32, 1};
      vecs[3] = '{mk(9, 2, 3, 8, 4, 1, 1, 4),  11'd7,   11'd3,   50, 15, 10, 1};
      c19 = mk(19, 2, 3, 8, 4, 1, 1, 4);
      cb  = mk(14, 3, 2, 12, 3, 1, 0, 3);

      vif.cfg_valid = 1'b0;
      set_cfg('0);
      model_reset();
      #12;
      @(negedge pclk);
      reset_n = 1'b1;
      chk("reset_px", 32'(px), 0);
      chk("reset_cfg_ready", 32'(vif.cfg_ready), 1);
      chk("reset_flags", 32'({hsync, vsync, de, frame_start}), 0);
      repeat (3) cycle();

      // Table of timing sets: load in idle, run, count flags over one frame
      foreach (vecs[v]) begin
         enable = 1'b0;
         repeat (PD + 2) cycle();
         set_cfg(vecs[v].c);
         vif.cfg_valid = 1'b1;
         cycle();
         vif.cfg_valid = 1'b0;
         repeat (2) cycle();
         chk($sformatf("vec%0d_xend", v), 32'(xend), 32'(vecs[v].xend));
         chk($sformatf("vec%0d_yend", v), 32'(yend), 32'(vecs[v].yend));
         enable = 1'b1;
         cycle();
         chk($sformatf("vec%0d_origin", v), 32'({px, py}), 0);
         repeat (PD) cycle();
         n_de = 0; n_hs = 0; n_fs = 0;
         for (int k = 0; k < int'(vecs[v].len); k++) begin
            n_de += 32'(de); n_hs += 32'(hsync); n_fs += 32'(frame_start);
            cycle();
         end
         chk($sformatf("vec%0d_de_count", v), n_de, vecs[v].n_de);
         chk($sformatf("vec%0d_hsync_count", v), n_hs, vecs[v].n_hs);
         chk($sformatf("vec%0d_fs_count", v), n_fs, vecs[v].n_fs);
      end

      // Mid-frame config: old timing holds to the end of the frame
      wait_xy(2, 1, "s3_wait_start");
      set_cfg(c19);
      vif.cfg_valid = 1'b1;
      cycle();
      vif.cfg_valid = 1'b0;
      chk("s3_ready_low", 32'(vif.cfg_ready), 0);
      wait_xy(9, 4, "s3_wait_eof");
      chk("s3_ready_at_eof", 32'(vif.cfg_ready), 0);
      chk("s3_old_xend", 32'(xend), 7);
      cycle();
      chk("s3_wrap", 32'({px, py}), 0);
      chk("s3_ready_back", 32'(vif.cfg_ready), 1);
      repeat (19) cycle();
      chk("s3_px19", 32'(px), 19);
      cycle();
      chk("s3_line_wrap", 32'({px, py}), 32'({11'd0, 11'd1}));

      // Valid held while pending: one capture, only once ready returns
      vif.cfg_valid = 1'b1;
      cycle();
      chk("s4_pending", 32'(vif.cfg_ready), 0);
      set_cfg(cb);
      wait_ready("s4_wait_ready");
      cycle();
      vif.cfg_valid = 1'b0;
      chk("s4_captured", 32'(vif.cfg_ready), 0);
      wait_ready("s4_wait_switch");
      chk("s4_xend", 32'(xend), 11);
      chk("s4_origin", 32'({px, py}), 0);

      // Enable drop mid-frame and restart
      wait_xy(5, 2, "s5_wait");
      enable = 1'b0;
      cycle();
      chk("s5_origin", 32'({px, py}), 0);
      repeat (3) cycle();
      chk("s5_de_tail", 32'(de), 1);
      cycle();
      chk("s5_flags_low", 32'({hsync, vsync, de, frame_start}), 0);
      enable = 1'b1;
      cycle();
      repeat (3) cycle();
      chk("s5_fs_early", 32'(frame_start), 0);
      cycle();
      chk("s5_fs_pulse", 32'(frame_start), 1);
      cycle();
      chk("s5_fs_single", 32'(frame_start), 0);

      // Asynchronous reset while running
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         if (de && px != '0) found = 1'b1;
         else cycle();
      end
      if (!found) fail_timeout("s1_wait_de");
      #3;
      reset_n = 1'b0;
      #1;
      chk("s1_px_py", 32'({px, py}), 0);
      chk("s1_flags", 32'({hsync, vsync, de, frame_start}), 0);
      chk("s1_cfg_ready", 32'(vif.cfg_ready), 1);
      model_reset();
      @(negedge pclk);
      reset_n = 1'b1;

      // Random enable/config traffic against the model
      for (int i = 0; i < 3000; i++) begin
         if (enable) begin
            if ($urandom_range(0, 39) == 0) enable = 1'b0;
         end else if ($urandom_range(0, 4) == 0) begin
            enable = 1'b1;
         end
         if ($urandom_range(0, 14) == 0) begin
            set_cfg(rand_cfg());
            vif.cfg_valid = 1'b1;
         end else if ($urandom_range(0, 2) == 0) begin
            vif.cfg_valid = 1'b0;
         end
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
